// File: rtl/xorshift_256_pkg.sv
// xorshift_256_pkg: shared width, constants, default shifts and SplitMix256 mixer.
package xorshift_256_pkg;
  localparam int W = 256;
  typedef logic [W-1:0] word_t;
  localparam word_t GAMMA = {4{64'h9E3779B97F4A7C15}};
  localparam word_t M1 = {4{64'hBF58476D1CE4E5B9}};
  localparam word_t M2 = {4{64'h94D049BB133111EB}};
  localparam int SHIFT_A_DEF = 23;
  localparam int SHIFT_B_DEF = 17;
  localparam int SHIFT_C_DEF = 26;
  function automatic word_t splitmix(input word_t s);
    word_t z;
    z = s + GAMMA;
    z = (z ^ (z >> 30)) * M1;
    z = (z ^ (z >> 27)) * M2;
    return z ^ (z >> 31);
  endfunction
endpackage

// File: rtl/xorshift_256_if.sv
// xorshift_256_if: seed-load strobe, seed words and random result.
interface xorshift_256_if;
  import xorshift_256_pkg::*;
  logic set;
  word_t seed1;
  word_t seed2;
  word_t result;
  modport master(output set, output seed1, output seed2, input result);
  modport slave(input set, input seed1, input seed2, output result);
endinterface

// File: rtl/xorshift_256_splitmix.sv
// splitmix_256: registered SplitMix256 seed conditioner.
module splitmix_256
  import xorshift_256_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  word_t din,
  output word_t dout
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dout <= '0;
    else dout <= splitmix(din);
endmodule

// File: rtl/xorshift_256.sv
// xorshift_256: 256-bit xorshift+ generator, one word per clock.
// Define XORSHIFT_256_SPLITMIX_EN to condition seeds through SplitMix256 (adds one cycle).
module xorshift_256
  import xorshift_256_pkg::*;
#(
  parameter int SHIFT_A = SHIFT_A_DEF,
  parameter int SHIFT_B = SHIFT_B_DEF,
  parameter int SHIFT_C = SHIFT_C_DEF
) (
  input logic clk,
  input logic rst_n,
  xorshift_256_if.slave bus
);
  word_t s0, s1, res, ld1, ld2, t, n;
`ifdef XORSHIFT_256_SPLITMIX_EN
  splitmix_256 u_sm1 (.clk(clk), .rst_n(rst_n), .din(bus.seed1), .dout(ld1));
  splitmix_256 u_sm2 (.clk(clk), .rst_n(rst_n), .din(bus.seed2), .dout(ld2));
`else
  assign ld1 = bus.seed1;
  assign ld2 = bus.seed2;
`endif
  always_comb begin
    t = s0 ^ (s0 << SHIFT_A);
    n = t ^ s1 ^ (t >> SHIFT_B) ^ (s1 >> SHIFT_C);
  end
  // an all-zero seed pair would lock the generator at zero, so S0 takes GAMMA
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0 <= '0;
      s1 <= '0;
      res <= '0;
    end else if (bus.set) begin
      s0 <= (ld1 == '0 && ld2 == '0) ? GAMMA : ld1;
      s1 <= ld2;
      res <= '0;
    end else begin
      s0 <= s1;
      s1 <= n;
      res <= n + s1;
    end
  assign bus.result = res;
endmodule

// File: tb/tb_xorshift_256.sv
// tb_xorshift_256: table-driven and randomized checks against a reference model.
module tb_xorshift_256;
  import xorshift_256_pkg::*;
  typedef struct {
    logic  st;
    word_t a;
    word_t b;
    word_t exp;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int failures = 0;
  word_t m0, m1, m_res, mc1, mc2;
  xorshift_256_if bus();
  xorshift_256 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic word_t ones();
    word_t r;
    r = '0;
    return ~r;
  endfunction
  function automatic word_t rnd();
    word_t r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction
  function automatic word_t ref_mix(input word_t s);
    word_t z;
    z = s + {4{64'h9E3779B97F4A7C15}};
    z = (z ^ (z >> 30)) * {4{64'hBF58476D1CE4E5B9}};
    z = (z ^ (z >> 27)) * {4{64'h94D049BB133111EB}};
    return z ^ (z >> 31);
  endfunction
  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m0 = '0; m1 = '0; m_res = '0; mc1 = '0; mc2 = '0;
  endtask
  task automatic tick(input logic st, input word_t a, input word_t b);
    word_t l1, l2, x, y, t, n;
    @(negedge clk);
    bus.set = st; bus.seed1 = a; bus.seed2 = b;
    @(posedge clk);
    #1;
`ifdef XORSHIFT_256_SPLITMIX_EN
    l1 = mc1; l2 = mc2;
    mc1 = ref_mix(a); mc2 = ref_mix(b);
`else
    l1 = a; l2 = b;
`endif
    if (st) begin
      m0 = (l1 == '0 && l2 == '0) ? {4{64'h9E3779B97F4A7C15}} : l1;
      m1 = l2;
      m_res = '0;
    end else begin
      x = m0; y = m1;
      t = x ^ (x << 23);
      n = t ^ y ^ (t >> 17) ^ (y >> 26);
      m0 = y; m1 = n; m_res = n + y;
    end
    chk("model_result", bus.result, m_res);
  endtask
  initial begin
    vec_t tbl[6];
    word_t w;
    w = ones();
    bus.set = 0; bus.seed1 = '0; bus.seed2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk("reset_result", bus.result, '0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 10; i++) tick(0, '0, '0);
    chk("idle_s0", dut.s0, '0);
`ifndef XORSHIFT_256_SPLITMIX_EN
    tbl[0] = '{1'b1, 256'd1, '0, '0};
    tbl[1] = '{1'b0, '0, '0, 256'h800041};
    tbl[2] = '{1'b0, '0, '0, 256'h1000082};
    tbl[3] = '{1'b1, '0, w, '0};
    tbl[4] = '{1'b0, '0, '0, w & ~(256'd1 << 230)};
    tbl[5] = '{1'b1, '0, '0, '0};
    for (int i = 0; i < 6; i++) begin
      tick(tbl[i].st, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d", i), bus.result, tbl[i].exp);
      if (i == 2) chk("s0_after_two_steps", dut.s0, 256'h800041);
    end
    chk("zero_guard_s0", dut.s0, {4{64'h9E3779B97F4A7C15}});
    for (int i = 0; i < 5; i++) begin
      tick(0, '0, '0);
      checks++;
      if (bus.result == '0) begin
        failures++;
        $display("FAIL zero_guard_nonzero step=%0d got=%h", i, bus.result);
      end
    end
`else
    tick(1, 256'd1, '0);
    tick(1, 256'd1, '0);
    chk("sm_s0", dut.s0, ref_mix(256'd1));
    chk("sm_s1", dut.s1, ref_mix('0));
    for (int i = 0; i < 5; i++) tick(0, rnd(), rnd());
`endif
    for (int i = 0; i < 4; i++) begin
      tick(1, rnd(), rnd());
      chk("set_held", bus.result, '0);
    end
    repeat (3) tick(0, '0, '0);
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk("async_reset", bus.result, '0);
    model_reset();
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) tick(1, '0, '0);
      else tick($urandom_range(0, 7) == 0, rnd(), rnd());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xorshift_256.md
# xorshift_256

256-bit xorshift+ pseudo-random number generator producing one 256-bit word per clock. Two 256-bit seed words are loaded while `set` is high. Once `set` is released, the generator steps its state every cycle. It is the random source feeding the elliptic-curve datapath. An optional SplitMix256 seed-conditioning stage can be compiled in front of the seed load.

## Interface
- `SHIFT_A`, default 23 — left-shift amount applied to the old first state word.
- `SHIFT_B`, default 17 — right-shift amount applied to the mixed first word.
- `SHIFT_C`, default 26 — right-shift amount applied to the old second state word.
- `clk`  in  1  sole clock; all flops rise-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `set`  in  1  seed-load strobe, level-sensitive, sampled on rising `clk`.
- `seed1`  in  256  seed for state word S0.
- `seed2`  in  256  seed for state word S1.
- `result`  out  256  registered random output.

## Operation
- State: two 256-bit registers S0 and S1.
- Reset (`rst_n`=0, asynchronous):
  - S0, S1 and `result` are all zero.
  - Any pending seed-conditioning register is also zero.
- Load (`set`=1 at a rising edge):
  - S0 ← seed1 and S1 ← seed2.
  - `result` ← 0.
  - If seed1 and seed2 are both zero, S0 ← GAMMA instead. This keeps the state from being stuck at all-zero.
- Step (`set`=0 at a rising edge), with x=S0 and y=S1:
  - t = x ^ (x << SHIFT_A)
  - n = t ^ y ^ (t >> SHIFT_B) ^ (y >> SHIFT_C)
  - S0 ← y and S1 ← n
  - `result` ← (n + y) mod 2^256
- Arithmetic rules:
  - All shifts are logical, within 256 bits, and zero-fill.
  - The addition wraps with no carry out.
- Simultaneous events:
  - `rst_n` low overrides everything.
  - `set` high overrides a step.
- Holding `set` high keeps reloading the seeds and holds `result` at 0.

## Timing
- Step latency is 1 cycle: `result` reflects the step taken at the same edge.
- The first valid random word appears at the first rising edge with `set`=0 after a load.
- Throughput is one word per cycle; there is no handshake and no stall.
- Reset asserted mid-run returns every register to zero immediately.
- Until the next load, reset state steps as zero forever, so `result` stays 0.

## Configuration
- Macro: `XORSHIFT_256_SPLITMIX_EN`.
- Defined:
  - seed1 and seed2 each pass through a registered SplitMix256 stage before the load mux.
  - SplitMix output per seed s:
    - z = s + GAMMA
    - z = (z ^ (z>>30)) * M1
    - z = (z ^ (z>>27)) * M2
    - out = z ^ (z>>31)
    - All operations are mod 2^256.
  - Conditioned seeds lag the raw inputs by 1 cycle, so `set` must be high for ≥2 edges to load conditioned values.
  - The all-zero check applies to the conditioned values.
- Undefined: seeds are loaded raw with no extra latency.

## Structure
- Shared package `xorshift_256_pkg` holds:
  - width constant `W`=256.
  - GAMMA = {4{64'h9E3779B97F4A7C15}}.
  - M1 = {4{64'hBF58476D1CE4E5B9}}.
  - M2 = {4{64'h94D049BB133111EB}}.
  - default shift values.
- One sub-module `splitmix_256` (clk, rst_n, 256-bit in, registered 256-bit out) is instantiated twice, only under the macro.

## Test plan
- Reset: with `rst_n`=0, `result`=0. After release with `set`=0 and no load, `result` stays 0 for 10 cycles.
- Load seed1=1, seed2=0, then drop `set`:
  - first step `result`=0x800041;
  - second step `result`=0x1000082;
  - S0 equals 0x800041 after the second step.
- Wrap-around: seed1=0, seed2=all-ones, one step → `result`=256'hFFFFFFBFFF…F, i.e. bit 230 clear and all other bits set.
- Zero-seed guard: seed1=seed2=0 with `set` pulsed → S0=GAMMA, and every `result` after the first step is non-zero.
- `set` held high across steps keeps `result`=0. Asserting `rst_n`=0 mid-stream zeroes `result` asynchronously, without waiting for a clock edge.
- With `XORSHIFT_256_SPLITMIX_EN` defined and seed1=1, seed2=0, `set` high for 2 edges → S0 and S1 equal the SplitMix formula of 1 and of 0, and the sequence matches a software model.
